// File: rtl/fu_arbiter.sv
// Two-requester round-robin arbiter feeding one shared combinational FunctionUnit
// through a registered issue stage, with a registered response stage and backpressure.
module fu_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [3:0]       req0_FS,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [3:0]       req1_FS,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [WIDTH-1:0] fu_A,
  output logic [WIDTH-1:0] fu_B,
  output logic [3:0]       fu_FS,
  input  logic [WIDTH-1:0] fu_S,
  input  logic [3:0]       fu_ZCNV,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_S,
  output logic [3:0]       rsp_ZCNV,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam logic [3:0] FS_ADD  = 4'b0000;
  localparam logic [3:0] FS_SUB  = 4'b0001;
  localparam logic [3:0] FS_SLL  = 4'b0010;
  localparam logic [3:0] FS_SLT  = 4'b0100;
  localparam logic [3:0] FS_SLTU = 4'b0110;
  localparam logic [3:0] FS_XOR  = 4'b1000;
  localparam logic [3:0] FS_SRL  = 4'b1010;
  localparam logic [3:0] FS_SRA  = 4'b1011;
  localparam logic [3:0] FS_OR   = 4'b1100;
  localparam logic [3:0] FS_AND  = 4'b1110;

  function automatic logic fs_legal(input logic [3:0] fs);
    logic legal;
    case (fs)
      FS_ADD, FS_SUB, FS_SLL, FS_SLT, FS_SLTU,
      FS_XOR, FS_SRL, FS_SRA, FS_OR, FS_AND: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

  logic             last_grant_r;
  logic             iss_valid_r;
  logic [WIDTH-1:0] iss_a_r;
  logic [WIDTH-1:0] iss_b_r;
  logic [3:0]       iss_fs_r;
  logic             iss_id_r;
  logic [TAG_W-1:0] iss_tag_r;

  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_s_r;
  logic [3:0]       rsp_zcnv_r;
  logic             rsp_id_r;
  logic [TAG_W-1:0] rsp_tag_r;
  logic             rsp_err_r;

  logic             grant0_s;
  logic             grant1_s;
  logic             stall2_s;
  logic             s1_accept_s;
  logic             hs0_s;
  logic             hs1_s;
  logic             adv2_s;
  logic             iss_err_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [3:0]       sel_fs_s;
  logic [TAG_W-1:0] sel_tag_s;

  // Arbitration, pipeline flow control and granted-payload selection
  always_comb begin
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    sel_a_s     = req0_A;
    sel_b_s     = req0_B;
    sel_fs_s    = req0_FS;
    sel_tag_s   = req0_tag;
    stall2_s    = rsp_valid_r & ~rsp_ready;
    s1_accept_s = ~iss_valid_r | ~stall2_s;
    // On a tie the requester that did not win last time takes the grant.
    if (req0_valid & req1_valid) begin
      if (last_grant_r) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
    if (grant1_s) begin
      sel_a_s   = req1_A;
      sel_b_s   = req1_B;
      sel_fs_s  = req1_FS;
      sel_tag_s = req1_tag;
    end else begin
      sel_a_s   = req0_A;
      sel_b_s   = req0_B;
      sel_fs_s  = req0_FS;
      sel_tag_s = req0_tag;
    end
    hs0_s     = grant0_s & s1_accept_s;
    hs1_s     = grant1_s & s1_accept_s;
    adv2_s    = iss_valid_r & ~stall2_s;
    iss_err_s = ~fs_legal(iss_fs_r);
  end

  // Round-robin pointer, moved only by a completed request handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (hs0_s) begin
      last_grant_r <= 1'b0;
    end else if (hs1_s) begin
      last_grant_r <= 1'b1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Issue register; it is the only source of the FunctionUnit operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_r <= 1'b0;
      iss_a_r     <= {WIDTH{1'b0}};
      iss_b_r     <= {WIDTH{1'b0}};
      iss_fs_r    <= 4'b0000;
      iss_id_r    <= 1'b0;
      iss_tag_r   <= {TAG_W{1'b0}};
    end else if (s1_accept_s) begin
      iss_valid_r <= hs0_s | hs1_s;
      if (hs0_s | hs1_s) begin
        iss_a_r   <= sel_a_s;
        iss_b_r   <= sel_b_s;
        iss_fs_r  <= sel_fs_s;
        iss_id_r  <= hs1_s;
        iss_tag_r <= sel_tag_s;
      end
    end
  end

  // Response register; illegal opcodes return zero result and flags with err set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_s_r     <= {WIDTH{1'b0}};
      rsp_zcnv_r  <= 4'b0000;
      rsp_id_r    <= 1'b0;
      rsp_tag_r   <= {TAG_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (adv2_s) begin
      rsp_valid_r <= 1'b1;
      rsp_s_r     <= iss_err_s ? {WIDTH{1'b0}} : fu_S;
      rsp_zcnv_r  <= iss_err_s ? 4'b0000 : fu_ZCNV;
      rsp_id_r    <= iss_id_r;
      rsp_tag_r   <= iss_tag_r;
      rsp_err_r   <= iss_err_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign req0_ready = hs0_s;
  assign req1_ready = hs1_s;
  assign fu_A       = iss_a_r;
  assign fu_B       = iss_b_r;
  assign fu_FS      = iss_fs_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_S      = rsp_s_r;
  assign rsp_ZCNV   = rsp_zcnv_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_tag    = rsp_tag_r;
  assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_fu_arbiter.sv
// Bench for fu_arbiter: behavioural FunctionUnit, queue-based reference model,
// table of hand-computed vectors and directed multi-cycle sequences.
module tb_fu_arbiter;
  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_A, req0_B, req1_A, req1_B;
  logic [3:0]    req0_FS, req1_FS;
  logic [TW-1:0] req0_tag, req1_tag;
  logic [W-1:0]  fu_A, fu_B, fu_S;
  logic [3:0]    fu_FS, fu_ZCNV;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0]  rsp_S;
  logic [3:0]    rsp_ZCNV;
  logic [TW-1:0] rsp_tag;

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic [3:0] fs; logic id; logic [TW-1:0] tag; } op_t;
  typedef struct packed { logic [W-1:0] s; logic [3:0] zcnv; logic err; } res_t;
  typedef struct packed { logic [W-1:0] s; logic [3:0] zcnv; logic id; logic [TW-1:0] tag; logic err; } obs_t;
  typedef struct packed {
    logic who; logic [W-1:0] a; logic [W-1:0] b; logic [3:0] fs; logic [TW-1:0] tag;
    logic [W-1:0] exp_s; logic [3:0] exp_zcnv; logic exp_err;
  } vec_t;

  fu_arbiter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_FS(req0_FS), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_FS(req1_FS), .req1_tag(req1_tag),
    .fu_A(fu_A), .fu_B(fu_B), .fu_FS(fu_FS), .fu_S(fu_S), .fu_ZCNV(fu_ZCNV),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_S(rsp_S), .rsp_ZCNV(rsp_ZCNV),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [3:0] fs);
    return fs inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
                      4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110};
  endfunction

  // Behavioural FunctionUnit; unknown opcodes produce deliberate garbage.
  function automatic res_t alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fs);
    logic [W:0]   wide;
    logic [W-1:0] s;
    logic         c, v;
    wide = '0; s = '0; c = 1'b0; v = 1'b0;
    case (fs)
      4'b0000: begin wide = {1'b0, a} + {1'b0, b}; s = wide[W-1:0]; c = wide[W];
                     v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
      4'b0001: begin wide = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1}; s = wide[W-1:0]; c = wide[W];
                     v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]); end
      4'b0010: s = a << b[4:0];
      4'b0100: s = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0110: s = {{(W-1){1'b0}}, (a < b)};
      4'b1000: s = a ^ b;
      4'b1010: s = a >> b[4:0];
      4'b1011: s = W'($signed(a) >>> b[4:0]);
      4'b1100: s = a | b;
      4'b1110: s = a & b;
      default: return {a ^ b ^ 32'hDEADBEEF, 4'hF, 1'b0};
    endcase
    return {s, (s == {W{1'b0}}), c, s[W-1], v, 1'b0};
  endfunction

  function automatic res_t expect_rsp(input op_t op);
    if (is_legal(op.fs)) return alu(op.a, op.b, op.fs);
    return {{W{1'b0}}, 4'b0000, 1'b1};
  endfunction

  res_t fu_res;
  assign fu_res  = alu(fu_A, fu_B, fu_FS);
  assign fu_S    = fu_res.s;
  assign fu_ZCNV = fu_res.zcnv;

  int   checks = 0, errors = 0;
  op_t  m_iss[$], m_rsp[$];
  bit   mp;
  bit   d_valid[2];
  op_t  d_op[2];
  bit   fixed_mode = 1'b0;
  op_t  fix_op[2];
  int   acc_cnt, rsp_cnt, first_rsp_step, step_no;
  bit   grant_hist[$];
  obs_t rsp_hist[$];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op(input logic id);
    op_t op;
    op.a = pick_val(); op.b = pick_val();
    op.fs = 4'($urandom_range(0, 15)); op.id = id; op.tag = TW'($urandom_range(0, 15));
    return op;
  endfunction

  task automatic drive_ports();
    req0_valid = d_valid[0]; req0_A = d_op[0].a; req0_B = d_op[0].b; req0_FS = d_op[0].fs; req0_tag = d_op[0].tag;
    req1_valid = d_valid[1]; req1_A = d_op[1].a; req1_B = d_op[1].b; req1_FS = d_op[1].fs; req1_tag = d_op[1].tag;
  endtask

  task automatic model_reset();
    m_iss.delete(); m_rsp.delete(); mp = 1'b1; d_valid[0] = 1'b0; d_valid[1] = 1'b0;
  endtask

  // One clock cycle: drive at negedge, compare just after, advance the model at posedge.
  task automatic step(input bit new0, input bit new1, input bit rr);
    bit stall, acc, g0, g1, e0, e1;
    res_t ex;
    obs_t ob;
    @(negedge clk);
    if (!d_valid[0] && new0) begin d_valid[0] = 1'b1; d_op[0] = fixed_mode ? fix_op[0] : rand_op(1'b0); end
    if (!d_valid[1] && new1) begin d_valid[1] = 1'b1; d_op[1] = fixed_mode ? fix_op[1] : rand_op(1'b1); end
    drive_ports();
    rsp_ready = rr;
    #1;
    stall = (m_rsp.size() != 0) && !rr;
    acc   = (m_iss.size() == 0) || !stall;
    g0 = d_valid[0] && (!d_valid[1] || mp);
    g1 = d_valid[1] && (!d_valid[0] || !mp);
    e0 = g0 && acc;
    e1 = g1 && acc;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp_valid", rsp_valid, m_rsp.size() != 0);
    if (m_rsp.size() != 0) begin
      ex = expect_rsp(m_rsp[0]);
      chk("rsp_S", rsp_S, ex.s);
      chk("rsp_ZCNV", rsp_ZCNV, ex.zcnv);
      chk("rsp_err", rsp_err, ex.err);
      chk("rsp_id", rsp_id, m_rsp[0].id);
      chk("rsp_tag", rsp_tag, m_rsp[0].tag);
    end
    if (m_iss.size() != 0) begin
      chk("fu_A", fu_A, m_iss[0].a);
      chk("fu_B", fu_B, m_iss[0].b);
      chk("fu_FS", fu_FS, m_iss[0].fs);
    end
    if (req0_valid && req0_ready) acc_cnt++;
    if (req1_valid && req1_ready) acc_cnt++;
    if (req0_ready) grant_hist.push_back(1'b0);
    else if (req1_ready) grant_hist.push_back(1'b1);
    if (rsp_valid) begin
      if (first_rsp_step < 0) first_rsp_step = step_no;
      ob = {rsp_S, rsp_ZCNV, rsp_id, rsp_tag, rsp_err};
      rsp_hist.push_back(ob);
      if (rr) rsp_cnt++;
    end
    step_no++;
    @(posedge clk);
    if ((m_rsp.size() != 0) && rr) void'(m_rsp.pop_front());
    if ((m_iss.size() != 0) && !stall) m_rsp.push_back(m_iss.pop_front());
    if (e0) begin m_iss.push_back(d_op[0]); mp = 1'b0; d_valid[0] = 1'b0; end
    else if (e1) begin m_iss.push_back(d_op[1]); mp = 1'b1; d_valid[1] = 1'b0; end
  endtask

  initial begin
    // who, A, B, FS, tag, expected S, expected {Z,C,N,V}, expected err
    vecs[0]  = {1'b0, 32'h0000_0007, 32'h0000_0001, 4'b0000, 4'd3, 32'h0000_0008, 4'b0000, 1'b0};
    vecs[1]  = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 4'd1, 32'hFFFF_FFFE, 4'b0110, 1'b0};
    vecs[2]  = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 4'd2, 32'h0000_0000, 4'b1100, 1'b0};
    vecs[3]  = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0010, 4'd3, 32'h8000_0000, 4'b0010, 1'b0};
    vecs[4]  = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100, 4'd4, 32'h0000_0000, 4'b1000, 1'b0};
    vecs[5]  = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0110, 4'd5, 32'h0000_0000, 4'b1000, 1'b0};
    vecs[6]  = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 4'd6, 32'h0000_0000, 4'b1000, 1'b0};
    vecs[7]  = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010, 4'd7, 32'h0000_0001, 4'b0000, 1'b0};
    vecs[8]  = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1011, 4'd8, 32'hFFFF_FFFF, 4'b0010, 1'b0};
    vecs[9]  = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100, 4'd9, 32'hFFFF_FFFF, 4'b0010, 1'b0};
    vecs[10] = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1110, 4'd10, 32'hFFFF_FFFF, 4'b0010, 1'b0};
    vecs[11] = {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0011, 4'd11, 32'h0000_0000, 4'b0000, 1'b1};
    vecs[12] = {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1110, 4'd12, 32'hFFFF_FFFF, 4'b0010, 1'b0};
    vecs[13] = {1'b0, 32'h0000_0001, 32'h0000_0002, 4'b1111, 4'd13, 32'h0000_0000, 4'b0000, 1'b1};
    vecs[14] = {1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 4'd14, 32'h8000_0000, 4'b0011, 1'b0};

    rst = 1'b1; rsp_ready = 1'b0;
    d_op[0] = '0; d_op[1] = '0;
    model_reset(); drive_ports();
    acc_cnt = 0; rsp_cnt = 0; first_rsp_step = -1; step_no = 0;
    #3;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_S", rsp_S, 32'h0);
    chk("reset_rsp_ZCNV", rsp_ZCNV, 4'h0);
    chk("reset_rsp_id_tag_err", {rsp_id, rsp_tag, rsp_err}, 6'h0);
    chk("reset_fu_A_B", {fu_A, fu_B}, 64'h0);
    chk("reset_fu_FS", fu_FS, 4'h0);
    @(negedge clk); rst = 1'b0;

    // Tie from reset, then strict alternation while both stay valid
    fixed_mode = 1'b1;
    fix_op[0] = {32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 1'b0, 4'd1};
    fix_op[1] = {32'h0000_0007, 32'h0000_0007, 4'b0001, 1'b1, 4'd2};
    grant_hist.delete(); rsp_hist.delete();
    repeat (6) step(1'b1, 1'b1, 1'b1);
    chk("alt_grant_count", grant_hist.size(), 6);
    for (int i = 0; i < 4; i++)
      if (grant_hist.size() > i) chk("alt_grant_order", grant_hist[i], i % 2);
    chk("alt_rsp_count", rsp_hist.size() >= 2, 1'b1);
    if (rsp_hist.size() >= 2) begin
      chk("tie_rsp0", {rsp_hist[0].s, rsp_hist[0].zcnv, rsp_hist[0].id}, {32'h8000_0000, 4'b0011, 1'b0});
      chk("tie_rsp1", {rsp_hist[1].s, rsp_hist[1].zcnv, rsp_hist[1].id}, {32'h0000_0000, 4'b1100, 1'b1});
    end
    fixed_mode = 1'b0;
    repeat (5) step(1'b0, 1'b0, 1'b1);

    // Full backpressure: two ops buffered, response frozen, then lossless drain
    acc_cnt = 0; rsp_cnt = 0; rsp_hist.delete();
    repeat (5) step(1'b1, 1'b1, 1'b0);
    chk("bp_accepted", acc_cnt, 2);
    chk("bp_rsp_cycles", rsp_hist.size(), 3);
    for (int i = 1; i < rsp_hist.size(); i++) chk("bp_rsp_stable", rsp_hist[i], rsp_hist[0]);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    chk("bp_no_loss", rsp_cnt, acc_cnt);

    // Table-driven single operations with fixed expected results and latency
    for (int v = 0; v < 15; v++) begin
      d_valid[vecs[v].who] = 1'b1;
      d_op[vecs[v].who] = {vecs[v].a, vecs[v].b, vecs[v].fs, vecs[v].who, vecs[v].tag};
      first_rsp_step = -1; step_no = 0; rsp_hist.delete();
      repeat (5) step(1'b0, 1'b0, 1'b1);
      chk("vec_latency", first_rsp_step, 2);
      chk("vec_rsp_count", rsp_hist.size(), 1);
      if (rsp_hist.size() >= 1)
        chk("vec_result", rsp_hist[0],
            {vecs[v].exp_s, vecs[v].exp_zcnv, vecs[v].who, vecs[v].tag, vecs[v].exp_err});
    end

    // Randomised traffic against the reference model
    repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    repeat (10) step(1'b0, 1'b0, 1'b1);

    // Asynchronous reset with both stages occupied
    repeat (3) step(1'b1, 1'b1, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 1'b0);
    chk("async_rst_fu_FS", fu_FS, 4'h0);
    chk("async_rst_fu_A", fu_A, 32'h0);
    model_reset(); drive_ports();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_hist.delete();
    repeat (4) step(1'b0, 1'b0, 1'b1);
    chk("post_rst_no_rsp", rsp_hist.size(), 0);
    grant_hist.delete();
    step(1'b1, 1'b1, 1'b1);
    chk("post_rst_tie_count", grant_hist.size(), 1);
    if (grant_hist.size() >= 1) chk("post_rst_tie_req0", grant_hist[0], 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
